// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: frame-synchronous shadow, leading-zero blanking, PWM dimming.
// Optional lamp test (adds port lamp_test) is enabled by defining SEVEN_SEG_LAMP_TEST_EN.
module seven_seg_scan_ctrl #(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV_WIDTH = 16,
  parameter int BRIGHT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIGITS*4-1:0]     val,
  input  logic [DIGITS-1:0]       dp_in,
  input  logic [DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  input  logic                    lz_blank,
`ifdef SEVEN_SEG_LAMP_TEST_EN
  input  logic                    lamp_test,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [DIGITS-1:0]       an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CLK_DIV_WIDTH-1:0] slot_cnt_r;
  logic [IDX_W-1:0]         digit_idx_r;
  logic [DIGITS*4-1:0]      val_sh_r;
  logic [DIGITS-1:0]        dp_sh_r;
  logic [DIGITS-1:0]        en_sh_r;
  logic [BRIGHT_WIDTH-1:0]  bright_sh_r;
  logic                     lz_sh_r;
  logic [6:0]               seg_r;
  logic                     dp_r;
  logic [DIGITS-1:0]        an_r;

  logic                     slot_wrap_s;
  logic                     frame_end_s;
  logic                     lamp_s;
  logic [DIGITS-1:0]        supp_s;
  logic [3:0]               cur_nib_s;
  logic                     cur_en_s;
  logic                     cur_dp_s;
  logic                     cur_supp_s;
  logic                     visible_s;
  logic                     pwm_on_s;
  logic                     an_on_s;
  logic [6:0]               seg_nxt_s;
  logic                     dp_nxt_s;
  logic [DIGITS-1:0]        an_nxt_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef SEVEN_SEG_LAMP_TEST_EN
  assign lamp_s = lamp_test;
`else
  assign lamp_s = 1'b0;
`endif

  assign slot_wrap_s = &slot_cnt_r;
  assign frame_end_s = slot_wrap_s && (digit_idx_r == LAST_IDX);

  // Leading-zero mask: digit k>0 blanks when it and every more significant nibble is zero
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp_s   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (val_sh_r[4*k +: 4] == 4'h0);
      if (k != 0) begin
        supp_s[k] = lz_sh_r & zero_run;
      end else begin
        supp_s[k] = 1'b0;
      end
    end
  end

  // Next-output decode for the digit currently being scanned
  always_comb begin
    cur_nib_s  = val_sh_r[{digit_idx_r, 2'b00} +: 4];
    cur_en_s   = en_sh_r[digit_idx_r];
    cur_dp_s   = dp_sh_r[digit_idx_r];
    cur_supp_s = supp_s[digit_idx_r];
    visible_s  = lamp_s | (cur_en_s & (~cur_supp_s | cur_dp_s));
    pwm_on_s   = lamp_s | (slot_cnt_r[CLK_DIV_WIDTH-1 -: BRIGHT_WIDTH] < bright_sh_r);
    // slot_cnt==0 is the dead time that lets segments settle with every anode off
    an_on_s    = visible_s && (slot_cnt_r != '0) && pwm_on_s;
    if (lamp_s) begin
      seg_nxt_s = 7'h00;
      dp_nxt_s  = 1'b0;
    end else if (cur_en_s && !cur_supp_s) begin
      seg_nxt_s = seg_decode(cur_nib_s);
      dp_nxt_s  = ~cur_dp_s;
    end else begin
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = ~(cur_en_s & cur_dp_s);
    end
    an_nxt_s = {DIGITS{1'b1}};
    if (an_on_s) begin
      an_nxt_s[digit_idx_r] = 1'b0;
    end else begin
      an_nxt_s = {DIGITS{1'b1}};
    end
  end

  // Slot counter and digit scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r  <= '0;
      digit_idx_r <= '0;
    end else begin
      slot_cnt_r <= slot_cnt_r + CLK_DIV_WIDTH'(1);
      if (slot_wrap_s) begin
        if (digit_idx_r == LAST_IDX) begin
          digit_idx_r <= '0;
        end else begin
          digit_idx_r <= digit_idx_r + IDX_W'(1);
        end
      end
    end
  end

  // Shadow snapshot taken on the last clock of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_sh_r    <= '0;
      dp_sh_r     <= '0;
      en_sh_r     <= '0;
      bright_sh_r <= '0;
      lz_sh_r     <= 1'b0;
    end else if (frame_end_s) begin
      val_sh_r    <= val;
      dp_sh_r     <= dp_in;
      en_sh_r     <= digit_en;
      bright_sh_r <= brightness;
      lz_sh_r     <= lz_blank;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
      an_r  <= {DIGITS{1'b1}};
    end else begin
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule
